// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : ISA constants shared by the instruction encoder and its
//               field packer: mnemonic codes, opcode/func fields and the
//               encoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // Mnemonic codes presented on the mnem input (16-31 are illegal)
  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_XOR  = 5'd2;
  localparam logic [4:0] MN_AND  = 5'd3;
  localparam logic [4:0] MN_OR   = 5'd4;
  localparam logic [4:0] MN_SLT  = 5'd5;
  localparam logic [4:0] MN_SLE  = 5'd6;
  localparam logic [4:0] MN_ADDI = 5'd7;
  localparam logic [4:0] MN_SUBI = 5'd8;
  localparam logic [4:0] MN_XORI = 5'd9;
  localparam logic [4:0] MN_ANDI = 5'd10;
  localparam logic [4:0] MN_ORI  = 5'd11;
  localparam logic [4:0] MN_LW   = 5'd12;
  localparam logic [4:0] MN_SW   = 5'd13;
  localparam logic [4:0] MN_BEQ  = 5'd14;
  localparam logic [4:0] MN_BNE  = 5'd15;

  // R-type opcode and function fields
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b000011;
  localparam logic [5:0] FN_SUB   = 6'b000010;
  localparam logic [5:0] FN_XOR   = 6'b000001;
  localparam logic [5:0] FN_AND   = 6'b000111;
  localparam logic [5:0] FN_OR    = 6'b000100;
  localparam logic [5:0] FN_SLT   = 6'b110110;
  localparam logic [5:0] FN_SLE   = 6'b110111;

  // I-type opcodes
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_SUBI = 6'b000010;
  localparam logic [5:0] OP_XORI = 6'b000001;
  localparam logic [5:0] OP_ANDI = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b011110;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;

  // Encoder session state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Purely combinational packing of a mnemonic and its register
//               / immediate fields into a 32-bit instruction word, plus an
//               illegal-mnemonic flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] func;
  logic [5:0] op;
  logic       r_type;

  // Decode mnemonic into format, opcode/func and legality, then pack fields
  always_comb begin
    func    = 6'b000000;
    op      = 6'b000000;
    r_type  = 1'b0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  begin r_type = 1'b1; func = FN_ADD; end
      MN_SUB:  begin r_type = 1'b1; func = FN_SUB; end
      MN_XOR:  begin r_type = 1'b1; func = FN_XOR; end
      MN_AND:  begin r_type = 1'b1; func = FN_AND; end
      MN_OR:   begin r_type = 1'b1; func = FN_OR;  end
      MN_SLT:  begin r_type = 1'b1; func = FN_SLT; end
      MN_SLE:  begin r_type = 1'b1; func = FN_SLE; end
      MN_ADDI: op = OP_ADDI;
      MN_SUBI: op = OP_SUBI;
      MN_XORI: op = OP_XORI;
      MN_ANDI: op = OP_ANDI;
      MN_ORI:  op = OP_ORI;
      MN_LW:   op = OP_LW;
      MN_SW:   op = OP_SW;
      MN_BEQ:  op = OP_BEQ;
      MN_BNE:  op = OP_BNE;
      default: illegal = 1'b1;
    endcase
    // rd is ignored for I-type; imm is ignored for R-type
    if (r_type) word = {OP_RTYPE, rs, rt, rd, 5'b00000, func};
    else        word = {op, rs, rt, imm};
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Streams instruction fields into encoded words and writes them
//               to consecutive instruction-memory addresses within a load
//               session (IDLE / LOAD / FULL).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;     // next address to be written
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              wr;

  instr_pack u_pack (
    .mnem    (mnem),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .imm     (imm),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign full        = (state_q == ST_FULL);
  assign err_illegal = err_q;
  assign count       = count_q;
  assign imem_we     = we_q;
  assign imem_addr   = waddr_q;
  assign imem_wdata  = wdata_q;

  assign accept = in_valid & in_ready;
  assign wr     = accept & ~illegal;

  // Next-state: write issue, address/count advance, then session control.
  // The write is captured at the old address before start can reload it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = wr;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (wr) begin
      waddr_d = addr_q;
      wdata_d = word;
      count_d = count_q + (ADDR_W+1)'(1);
      // The last address parks the session instead of wrapping
      if (addr_q == ADDR_LAST) state_d = ST_FULL;
      else                     addr_d  = addr_q + ADDR_W'(1);
    end
    if (accept && illegal) err_d = 1'b1;

    // stop overrides start and any FULL transition from this cycle's write
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_LOAD;
      addr_d  = base_addr;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: directed scenarios and
//               randomized traffic against a session-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, in_valid;
  logic [7:0]  base_addr;
  logic [4:0]  mnem, rd, rs, rt;
  logic [15:0] imm;
  logic        in_ready, imem_we, busy, full, err_illegal;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mnem        (mnem),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .full        (full),
    .err_illegal (err_illegal),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: session mode (0 idle, 1 loading, 2 full), next address,
  // word count, sticky error and the last word written to memory.
  int          m_mode;
  int          m_addr;
  int          m_count;
  bit          m_err;
  logic [7:0]  e_waddr;
  logic [31:0] e_wdata;

  // R-type func (codes 0-6) / I-type opcode (codes 7-15) by mnemonic
  int code_tab [16] = '{3, 2, 1, 7, 4, 54, 55, 3, 2, 1, 15, 12, 30, 31, 48, 49};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input int m, input int d, input int s,
                                         input int t, input int im);
    longint w;
    if (m < 7) w = s * 2**21 + t * 2**16 + d * 2**11 + code_tab[m];
    else       w = longint'(code_tab[m]) * 2**26 + s * 2**21 + t * 2**16 + im;
    return 32'(w);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_count = 0; m_err = 0;
    e_waddr = 8'h00; e_wdata = 32'h0;
  endtask

  task automatic check_reset_outputs();
    check("rst_we",    32'(imem_we),     32'd0);
    check("rst_addr",  32'(imem_addr),   32'd0);
    check("rst_wdata", imem_wdata,       32'd0);
    check("rst_count", 32'(count),       32'd0);
    check("rst_full",  32'(full),        32'd0);
    check("rst_err",   32'(err_illegal), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ready", 32'(in_ready),    32'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle of stimulus, model update and output comparison
  task automatic cycle(input bit st, input logic [7:0] ba, input bit sp, input bit v,
                       input logic [4:0] mn, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic [15:0] im);
    bit acc, wr, hit;
    @(negedge clk);
    start = st; base_addr = ba; stop = sp; in_valid = v;
    mnem = mn; rd = d; rs = s; rt = t; imm = im;
    #1 check("in_ready", 32'(in_ready), 32'(m_mode == 1));
    acc = v && (m_mode == 1);
    wr  = acc && (mn < 16);
    hit = 1'b0;
    if (wr) begin
      e_waddr = 8'(m_addr);
      e_wdata = encode(int'(mn), int'(d), int'(s), int'(t), int'(im));
      m_count++;
      if (m_addr == 255) hit = 1'b1;
      else               m_addr++;
    end
    if (acc && mn >= 16) m_err = 1'b1;
    if (sp)          m_mode = 0;
    else if (st) begin
      m_mode = 1; m_addr = int'(ba); m_count = 0; m_err = 1'b0;
    end else if (hit) m_mode = 2;
    @(posedge clk);
    #1;
    check("imem_we",    32'(imem_we),     32'(wr));
    check("imem_addr",  32'(imem_addr),   32'(e_waddr));
    check("imem_wdata", imem_wdata,       e_wdata);
    check("count",      32'(count),       32'(m_count));
    check("busy",       32'(busy),        32'(m_mode != 0));
    check("full",       32'(full),        32'(m_mode == 2));
    check("err",        32'(err_illegal), 32'(m_err));
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
  endtask

  task automatic instr(input logic [4:0] mn, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic [15:0] im);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, mn, d, s, t, im);
  endtask

  task automatic begin_session(input logic [7:0] ba);
    cycle(1'b1, ba, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; base_addr = 8'h00;
    mnem = 5'd0; rd = 5'd0; rs = 5'd0; rt = 5'd0; imm = 16'h0;
    model_reset();
    #3 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // ADD rd3 rs1 rt2 at base 0x10
    begin_session(8'h10);
    instr(5'd0, 5'd3, 5'd1, 5'd2, 16'h0);
    check("add_wdata", imem_wdata, 32'h00221803);
    check("add_addr",  32'(imem_addr), 32'h10);
    check("add_count", 32'(count), 32'd1);

    // ADDI then BNE back-to-back
    instr(5'd7, 5'd9, 5'd4, 5'd5, 16'h0010);
    check("addi_wdata", imem_wdata, 32'h0C850010);
    instr(5'd15, 5'd0, 5'd1, 5'd2, 16'hFFFE);
    check("bne_wdata", imem_wdata, 32'hC422FFFE);
    check("bne_addr",  32'(imem_addr), 32'h12);

    // SLE, then an illegal mnemonic
    instr(5'd6, 5'd7, 5'd5, 5'd6, 16'h1234);
    check("sle_wdata", imem_wdata, 32'h00A63837);
    instr(5'd20, 5'd1, 5'd1, 5'd1, 16'h0);
    check("ill_we",  32'(imem_we), 32'd0);
    check("ill_err", 32'(err_illegal), 32'd1);
    idle_cycle();

    // Filling the last two addresses
    begin_session(8'hFE);
    instr(5'd1, 5'd1, 5'd2, 5'd3, 16'h0);
    instr(5'd12, 5'd0, 5'd2, 5'd3, 16'h0004);
    check("full_addr", 32'(imem_addr), 32'hFF);
    instr(5'd13, 5'd0, 5'd2, 5'd3, 16'h0008);
    check("full_flag", 32'(full), 32'd1);
    check("full_noacc", 32'(imem_we), 32'd0);
    check("full_count", 32'(count), 32'd2);

    // Restart from FULL, then stop together with an accept
    begin_session(8'h20);
    instr(5'd4, 5'd1, 5'd2, 5'd3, 16'h0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 5'd9, 5'd0, 5'd3, 5'd4, 16'h00AA);
    check("stop_we", 32'(imem_we), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    // start and stop together: stop wins
    cycle(1'b1, 8'h30, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);

    // Reset in the middle of a stream, then resume at a new base
    begin_session(8'h50);
    for (int i = 0; i < 4; i++) instr(5'(i), 5'(i), 5'(i + 1), 5'(i + 2), 16'(i));
    do_reset();
    begin_session(8'h40);
    instr(5'd0, 5'd3, 5'd1, 5'd2, 16'h0);
    check("resume_addr", 32'(imem_addr), 32'h40);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit st, sp, v;
      logic [7:0] ba;
      st = ($urandom_range(0, 99) < 4);
      sp = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 75);
      ba = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) < 3) do_reset();
      cycle(st, ba, sp, v, 5'($urandom_range(0, 19)), 5'($urandom), 5'($urandom),
            5'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a load session at base_addr.
REQ-005 base_addr  input  ADDR_W  first word address written in the session.
REQ-006 stop  input  1  one-cycle pulse that ends the session.
REQ-007 in_valid  input  1  instruction fields below are valid.
REQ-008 in_ready  output  1  encoder accepts fields this cycle.
REQ-009 mnem  input  5  mnemonic code: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 SLT, 6 SLE, 7 ADDI, 8 SUBI, 9 XORI, 10 ANDI, 11 ORI, 12 LW, 13 SW, 14 BEQ, 15 BNE; 16-31 illegal.
REQ-010 rd, rs, rt  input  5 each  register fields.
REQ-011 imm  input  16  immediate or branch offset.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_addr  output  ADDR_W  write word address.
REQ-014 imem_wdata  output  32  encoded instruction word.
REQ-015 busy  output  1  session active (LOAD or FULL).
REQ-016 full  output  1  last address written; no further accepts.
REQ-017 err_illegal  output  1  sticky: an illegal mnem was accepted this session.
REQ-018 count  output  ADDR_W+1  words written this session.

Function
REQ-019 States IDLE, LOAD, FULL; IDLE->LOAD on start; LOAD->FULL when the word at address 2^ADDR_W-1 is written; LOAD or FULL->IDLE on stop.
REQ-020 in_ready = 1 only in LOAD; handshake completes on in_valid & in_ready.
REQ-021 On an accepted legal instruction, imem_we = 1 exactly one cycle later, with the registered imem_addr and imem_wdata; throughput one word per cycle.
REQ-022 R-type (mnem 0-6): word = {6'b000000, rs, rt, rd, 5'b00000, func}; func ADD 000011, SUB 000010, XOR 000001, AND 000111, OR 000100, SLT 110110, SLE 110111.
REQ-023 I-type (mnem 7-15): word = {op, rs, rt, imm}; rd ignored; op ADDI 000011, SUBI 000010, XORI 000001, ANDI 001111, ORI 001100, LW 011110, SW 011111, BEQ 110000, BNE 110001.
REQ-024 Write address starts at base_addr and increments by 1 after each write; count increments by 1 after each write.
REQ-025 Illegal mnem: handshake still completes, no write, address and count unchanged, err_illegal set until next start or reset.
REQ-026 Write at address 2^ADDR_W-1: full = 1 and in_ready = 0 from the next cycle; the address never wraps to 0.
REQ-027 start in LOAD or FULL: restart the session (reload base_addr, count = 0, clear full and err_illegal); a write already pending still completes at its old address.
REQ-028 stop and an accept in the same cycle: the instruction is written, then state = IDLE.
REQ-029 start and stop in the same cycle: stop wins.
REQ-030 imem_we = 0 in IDLE except for the write that completes a stop cycle accept.

Reset
REQ-031 rst_n low, at any time: state IDLE, imem_we = 0, imem_addr = 0, imem_wdata = 0, count = 0, full = 0, err_illegal = 0, busy = 0, in_ready = 0; a pending write is dropped.

Structure
REQ-032 Mnemonic codes, opcode and func constants, and the state encoding belong in a shared ISA package, together with the decoder's constants.
REQ-033 Pure combinational field packing is a sub-module instr_pack (mnem and fields -> word, illegal flag); FSM, counters and output registers live in instr_encoder.

Verification
REQ-034 start with base_addr = 0x10, then ADD rd3 rs1 rt2 -> next cycle imem_we = 1, addr 0x10, wdata 0x00221803, count = 1.
REQ-035 ADDI rs4 rt5 imm 0x0010, then BNE rs1 rt2 imm 0xFFFE, back-to-back -> wdata 0x0C850010 at addr N, then 0xC422FFFE at addr N+1, on consecutive cycles.
REQ-036 SLE rd7 rs5 rt6 -> 0x00A63837; mnem 20 -> no write, err_illegal = 1, address unchanged.
REQ-037 base_addr = 0xFE, three valid instructions -> writes at 0xFE and 0xFF, full = 1, third instruction not accepted (in_ready = 0).
REQ-038 Deassert rst_n during a streaming load -> all outputs at reset values immediately; start after release resumes at the new base_addr.
